// File: rtl/parity_serial_framer.sv
// -----------------------------------------------------------------------------
// parity_serial_framer
//
// Takes a WIDTH-bit word over a valid/ready handshake and sends it out
// LSB-first, one bit per clock, followed by a parity bit. After the parity bit
// it idles for GAP cycles before it accepts the next word. It also counts
// completed frames.
//
// Parameters
//   WIDTH : data bits per frame (>= 1)
//   ODD   : 0 = even parity (^data), 1 = odd parity (~^data)
//   GAP   : idle cycles after the parity bit (>= 0)
//
// Ports
//   clk_i         rising-edge clock
//   rst_n_i       asynchronous active-low reset
//   in_valid_i    producer presents a word on in_data_i
//   in_ready_o    framer can accept a word (IDLE only, decoded from state)
//   in_data_i     word to frame, sampled only on the accept edge
//   ser_out_o     serial bit: data LSB-first, then parity; 0 when not valid
//   ser_valid_o   ser_out_o carries a frame bit this cycle
//   ser_last_o    parity-bit cycle marker
//   busy_o        frame or gap in progress (decoded from state)
//   frame_cnt_o   completed-frame count, 8-bit wrapping
//
// States
//   S_IDLE  | waiting for in_valid_i; in_ready_o high
//   S_SHIFT | data bits 0..WIDTH-1 on the serial line
//   S_PAR   | parity bit on the serial line, ser_last_o high
//   S_GAP   | GAP idle cycles before the framer returns to S_IDLE
// -----------------------------------------------------------------------------
module parity_serial_framer #(
    parameter int WIDTH = 8,
    parameter bit ODD   = 1'b0,
    parameter int GAP   = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             ser_out_o,
    output logic             ser_valid_o,
    output logic             ser_last_o,
    output logic             busy_o,
    output logic [7:0]       frame_cnt_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);
    localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAR   = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [CW-1:0]    bit_cnt_q;
    logic [GW-1:0]    gap_cnt_q;
    logic             acc_q;
    logic             ser_out_q;
    logic             ser_valid_q;
    logic             ser_last_q;
    logic [7:0]       frame_cnt_q;

    assign in_ready_o  = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign ser_out_o   = ser_out_q;
    assign ser_valid_o = ser_valid_q;
    assign ser_last_o  = ser_last_q;
    assign frame_cnt_o = frame_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            acc_q       <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        // Bit 0 goes out on the accept edge itself. The shift
                        // register keeps only the bits that are still to be sent.
                        shift_q     <= in_data_i >> 1;
                        bit_cnt_q   <= CW'(1);
                        acc_q       <= ODD ^ in_data_i[0];
                        ser_out_q   <= in_data_i[0];
                        ser_valid_q <= 1'b1;
                        state_q     <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    // bit_cnt_q counts the bits already on the line. Once all
                    // of them are out, acc_q holds the finished parity.
                    if (bit_cnt_q == LAST_CNT) begin
                        ser_out_q  <= acc_q;
                        ser_last_q <= 1'b1;
                        state_q    <= S_PAR;
                    end else begin
                        ser_out_q <= shift_q[0];
                        acc_q     <= acc_q ^ shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                    end
                end

                S_PAR: begin
                    ser_out_q   <= 1'b0;
                    ser_valid_q <= 1'b0;
                    ser_last_q  <= 1'b0;
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                    if (GAP == 0) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= GAP_LOAD;
                        state_q   <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GW'(1);
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parity_serial_framer.sv
// -----------------------------------------------------------------------------
// tb_parity_serial_framer
//
// Four framer instances share one clock and one reset:
//   0: WIDTH=8 ODD=0 GAP=1   1: WIDTH=8 ODD=1 GAP=1
//   2: WIDTH=3 ODD=0 GAP=1   3: WIDTH=8 ODD=0 GAP=0
// Inputs are driven and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_parity_serial_framer;

    logic       clk;
    logic       rst_n;
    logic       v   [4];
    logic [7:0] d   [4];
    logic       rdy [4];
    logic       so  [4];
    logic       sv  [4];
    logic       sl  [4];
    logic       bsy [4];
    logic [7:0] fc  [4];
    logic [7:0] exp_fc [4];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    parity_serial_framer #(.WIDTH(8), .ODD(1'b0), .GAP(1)) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(v[0]), .in_ready_o(rdy[0]),
        .in_data_i(d[0]), .ser_out_o(so[0]), .ser_valid_o(sv[0]), .ser_last_o(sl[0]),
        .busy_o(bsy[0]), .frame_cnt_o(fc[0]));

    parity_serial_framer #(.WIDTH(8), .ODD(1'b1), .GAP(1)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(v[1]), .in_ready_o(rdy[1]),
        .in_data_i(d[1]), .ser_out_o(so[1]), .ser_valid_o(sv[1]), .ser_last_o(sl[1]),
        .busy_o(bsy[1]), .frame_cnt_o(fc[1]));

    parity_serial_framer #(.WIDTH(3), .ODD(1'b0), .GAP(1)) u_c (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(v[2]), .in_ready_o(rdy[2]),
        .in_data_i(d[2][2:0]), .ser_out_o(so[2]), .ser_valid_o(sv[2]), .ser_last_o(sl[2]),
        .busy_o(bsy[2]), .frame_cnt_o(fc[2]));

    parity_serial_framer #(.WIDTH(8), .ODD(1'b0), .GAP(0)) u_d (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(v[3]), .in_ready_o(rdy[3]),
        .in_data_i(d[3]), .ser_out_o(so[3]), .ser_valid_o(sv[3]), .ser_last_o(sl[3]),
        .busy_o(bsy[3]), .frame_cnt_o(fc[3]));

    // Sends one word into instance k and checks every cycle of the frame,
    // including the gap and the return to idle.
    task automatic send_frame(input int k, input int w, input int gap,
                              input logic [7:0] data, input logic exp_par,
                              input string tag);
        for (int c = 0; c < 40 && rdy[k] !== 1'b1; c++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (rdy[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_wait: in_ready=%b expected 1", tag, rdy[k]);
        end
        v[k] = 1'b1;
        d[k] = data;
        @(posedge clk); #1;
        v[k] = 1'b0;
        d[k] = ~data;
        for (int i = 0; i < w; i++) begin
            n_checks++;
            if ({sv[k], sl[k], so[k], bsy[k], rdy[k]} !== {1'b1, 1'b0, data[i], 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL %s bit%0d: valid/last/out/busy/ready=%b%b%b%b%b expected %b%b%b%b%b",
                         tag, i, sv[k], sl[k], so[k], bsy[k], rdy[k],
                         1'b1, 1'b0, data[i], 1'b1, 1'b0);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if ({sv[k], sl[k], so[k]} !== {1'b1, 1'b1, exp_par}) begin
            n_fail++;
            $display("FAIL %s parity: valid/last/out=%b%b%b expected 11%b",
                     tag, sv[k], sl[k], so[k], exp_par);
        end
        @(posedge clk); #1;
        exp_fc[k] = exp_fc[k] + 8'd1;
        n_checks++;
        if (fc[k] !== exp_fc[k]) begin
            n_fail++;
            $display("FAIL %s frame_cnt: got %0d expected %0d", tag, fc[k], exp_fc[k]);
        end
        for (int g = 0; g < gap; g++) begin
            n_checks++;
            if ({sv[k], sl[k], so[k], bsy[k], rdy[k]} !== 5'b00010) begin
                n_fail++;
                $display("FAIL %s gap%0d: valid/last/out/busy/ready=%b%b%b%b%b expected 00010",
                         tag, g, sv[k], sl[k], so[k], bsy[k], rdy[k]);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if ({rdy[k], bsy[k], sv[k]} !== 3'b100) begin
            n_fail++;
            $display("FAIL %s idle: ready/busy/valid=%b%b%b expected 100",
                     tag, rdy[k], bsy[k], sv[k]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            v[k] = 1'b0;
            d[k] = 8'h00;
            exp_fc[k] = 8'd0;
        end
        #3;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({sv[k], sl[k], so[k], bsy[k], rdy[k]} !== 5'b00001 || fc[k] !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: valid/last/out/busy/ready=%b%b%b%b%b cnt=%0d expected 00001 cnt=0",
                         k, sv[k], sl[k], so[k], bsy[k], rdy[k], fc[k]);
            end
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        send_frame(0, 8, 1, 8'hA5, 1'b0, "a5_even");
    endtask

    task automatic test_parity();
        send_frame(1, 8, 1, 8'h00, 1'b1, "00_odd");
        send_frame(0, 8, 1, 8'hFF, 1'b0, "ff_even");
        send_frame(0, 8, 1, 8'h01, 1'b1, "01_even");
    endtask

    task automatic test_xyz();
        logic [7:0] exp_tab;
        logic [7:0] word;
        exp_tab = 8'b1001_0110;   // parity of 0..7, index = xyz
        for (int n = 0; n < 8; n++) begin
            word = n[7:0];
            send_frame(2, 3, 1, word, exp_tab[n], "xyz");
        end
    endtask

    // in_valid stays high across two words; accept edges are found from the
    // ready level seen just before each edge.
    task automatic test_back_to_back(input int k, input int gap, input string tag);
        int   e;
        int   n;
        int   par_seen;
        int   acc_e [2];
        logic rdy_prev;
        e = 0;
        n = 0;
        par_seen = 0;
        acc_e[0] = 0;
        acc_e[1] = 0;
        v[k] = 1'b1;
        d[k] = 8'h01;
        rdy_prev = rdy[k];
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); e++; #1;
            if (rdy_prev && v[k]) begin
                acc_e[n] = e;
                n++;
                if (n == 1) d[k] = 8'h03;
                else        v[k] = 1'b0;
            end
            if (n > 0 && e == acc_e[n-1] + 8) begin
                par_seen++;
                n_checks++;
                if ({sv[k], sl[k], so[k]} !== {1'b1, 1'b1, (n == 1)}) begin
                    n_fail++;
                    $display("FAIL %s parity%0d: valid/last/out=%b%b%b expected 11%b",
                             tag, n, sv[k], sl[k], so[k], (n == 1));
                end
                if (n == 2) break;
            end
            rdy_prev = rdy[k];
        end
        n_checks++;
        if (n != 2 || par_seen != 2 || (acc_e[1] - acc_e[0]) != 10 + gap) begin
            n_fail++;
            $display("FAIL %s spacing: accepts=%0d parities=%0d spacing=%0d expected 2/2/%0d",
                     tag, n, par_seen, acc_e[1] - acc_e[0], 10 + gap);
        end
        v[k] = 1'b0;
        @(posedge clk); #1;
        exp_fc[k] = exp_fc[k] + 8'd2;
        n_checks++;
        if (fc[k] !== exp_fc[k]) begin
            n_fail++;
            $display("FAIL %s frame_cnt: got %0d expected %0d", tag, fc[k], exp_fc[k]);
        end
        repeat (gap) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (rdy[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_after: got %b expected 1", tag, rdy[k]);
        end
    endtask

    task automatic test_reset_mid_frame();
        v[0] = 1'b1;
        d[0] = 8'h08;
        @(posedge clk); #1;
        v[0] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if ({sv[0], so[0]} !== 2'b11) begin
            n_fail++;
            $display("FAIL midrst_bit3: valid/out=%b%b expected 11", sv[0], so[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) exp_fc[k] = 8'd0;
        n_checks++;
        if ({sv[0], sl[0], so[0], bsy[0], rdy[0]} !== 5'b00001 || fc[0] !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_clear: valid/last/out/busy/ready=%b%b%b%b%b cnt=%0d expected 00001 cnt=0",
                     sv[0], sl[0], so[0], bsy[0], rdy[0], fc[0]);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (rdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_ready: got %b expected 1", rdy[0]);
        end
        send_frame(0, 8, 1, 8'h3C, 1'b0, "after_rst");
    endtask

    task automatic test_wrap();
        logic [7:0] word;
        for (int i = 0; i < 256; i++) begin
            word = i[7:0];
            send_frame(3, 8, 0, word, ^word, "wrap");
            if (i == 254) begin
                n_checks++;
                if (fc[3] !== 8'd255) begin
                    n_fail++;
                    $display("FAIL wrap_255: got %0d expected 255", fc[3]);
                end
            end
        end
        n_checks++;
        if (fc[3] !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_0: got %0d expected 0", fc[3]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_xyz();
        test_back_to_back(0, 1, "b2b_gap1");
        test_back_to_back(3, 0, "b2b_gap0");
        test_reset_mid_frame();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
